// File: rtl/dot_product_accumulator.sv
// -----------------------------------------------------------------------------
// dot_product_accumulator
//
// Streams signed operand pairs (a, b) in over a valid/ready handshake and
// produces one dot product every K_LEN accepted pairs. The running sum lives in
// r_acc while the finished result waits in a separate holding register. The
// next group can therefore accumulate while the consumer has not yet taken the
// previous result. Only the pair that completes a group can be backpressured.
// Arithmetic wraps modulo 2^ACC_WIDTH.
//
// Ports:
//   clk      in   clock; all state updates on its rising edge
//   reset    in   synchronous active-high reset; overrides clk_en
//   clk_en   in   global stall; 0 freezes all state and blocks every transfer
//   i_a      in   [IN_WIDTH-1:0]  operand a, two's complement
//   i_b      in   [IN_WIDTH-1:0]  operand b, two's complement
//   i_valid  in   operand pair valid
//   i_ready  out  block accepts a pair this cycle (combinational)
//   o_data   out  [ACC_WIDTH-1:0] dot product result, two's complement
//   o_valid  out  o_data holds an unconsumed result
//   o_ready  in   consumer takes o_data this cycle
// -----------------------------------------------------------------------------
module dot_product_accumulator #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 48,
  parameter int K_LEN     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic [IN_WIDTH-1:0]  i_a,
  input  logic [IN_WIDTH-1:0]  i_b,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_data,
  output logic                 o_valid,
  input  logic                 o_ready
);

  localparam int                PROD_WIDTH = 2 * IN_WIDTH;
  localparam int                CNT_WIDTH  = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(K_LEN - 1);

  logic [ACC_WIDTH-1:0]        r_acc;
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic [ACC_WIDTH-1:0]        r_o_data;
  logic                        r_o_valid;

  logic signed [PROD_WIDTH-1:0] w_a_ext;
  logic signed [PROD_WIDTH-1:0] w_b_ext;
  logic signed [PROD_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]        w_prod_ext;
  logic [ACC_WIDTH-1:0]        w_acc_base;
  logic [ACC_WIDTH-1:0]        w_sum;
  logic                        w_last;
  logic                        w_acc_fire;
  logic                        w_out_fire;
  logic                        w_complete;

  // Explicit sign extension keeps both multiplier operands at the product
  // width, so the multiply is a plain same-width signed operation.
  assign w_a_ext    = {{IN_WIDTH{i_a[IN_WIDTH-1]}}, i_a};
  assign w_b_ext    = {{IN_WIDTH{i_b[IN_WIDTH-1]}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_WIDTH - PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};

  // The first pair of a group overwrites the accumulator rather than adding
  // to it. A group therefore never depends on what r_acc held before.
  assign w_acc_base = (r_cnt == '0) ? '0 : r_acc;
  assign w_sum      = w_acc_base + w_prod_ext;

  assign w_last     = (r_cnt == CNT_LAST);

  // Only the completing pair needs a free (or freeing) output slot; every
  // other pair is taken whenever the block is enabled.
  assign i_ready    = clk_en & (~w_last | ~r_o_valid | o_ready);
  assign w_acc_fire = clk_en & i_valid & i_ready;
  assign w_out_fire = clk_en & r_o_valid & o_ready;
  assign w_complete = w_acc_fire & w_last;

  // Accumulator and pair counter.
  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_acc_fire) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Output holding register. Completion takes precedence over consumption:
  // when both happen in one cycle the new result replaces the consumed one
  // and o_valid never drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_o_data  <= '0;
      r_o_valid <= 1'b0;
    end else if (w_complete) begin
      r_o_data  <= w_sum;
      r_o_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_o_valid <= 1'b0;
    end
  end

  assign o_data  = r_o_data;
  assign o_valid = r_o_valid;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// -----------------------------------------------------------------------------
// Testbench for dot_product_accumulator (K_LEN=4, IN_WIDTH=16, ACC_WIDTH=48).
// A reference model follows the handshake rules. It keeps the number of pairs
// taken in the current group, the exact running sum as a 64-bit integer, and
// the pending result. Directed scenarios run first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_dot_product_accumulator;

  localparam int IW = 16;
  localparam int AW = 48;
  localparam int K  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic [IW-1:0] i_a;
  logic [IW-1:0] i_b;
  logic          i_valid;
  logic          i_ready;
  logic [AW-1:0] o_data;
  logic          o_valid;
  logic          o_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int            m_pairs;
  longint        m_sum;
  logic          m_ov;
  logic [AW-1:0] m_od;

  dot_product_accumulator #(
    .IN_WIDTH (IW),
    .ACC_WIDTH(AW),
    .K_LEN    (K)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_valid(o_valid),
    .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input logic v);
    i_a     = IW'(a);
    i_b     = IW'(b);
    i_valid = v;
  endtask

  // One clock cycle. Outputs are compared against the model at the falling
  // edge. The model advances on the rising edge. Control then returns 1 time
  // unit later so the caller can change inputs.
  task automatic step();
    logic   exp_ready;
    logic   acc_fire;
    logic   out_fire;
    longint prod;
    @(negedge clk);
    exp_ready = clk_en && ((m_pairs != K - 1) || !m_ov || o_ready);
    check("i_ready", {63'd0, i_ready}, {63'd0, exp_ready});
    check("o_valid", {63'd0, o_valid}, {63'd0, m_ov});
    check("o_data",  {16'd0, o_data},  {16'd0, m_od});
    acc_fire = clk_en && i_valid && exp_ready;
    out_fire = clk_en && m_ov && o_ready;
    prod     = longint'($signed(i_a)) * longint'($signed(i_b));
    @(posedge clk);
    if (reset) begin
      m_pairs = 0;
      m_sum   = 0;
      m_ov    = 1'b0;
      m_od    = '0;
    end else begin
      if (out_fire) m_ov = 1'b0;
      if (acc_fire) begin
        if (m_pairs == K - 1) begin
          m_od    = AW'(m_sum + prod);
          m_ov    = 1'b1;
          m_pairs = 0;
          m_sum   = 0;
        end else begin
          m_sum   += prod;
          m_pairs++;
        end
      end
    end
    #1;
  endtask

  task automatic feed(input int a, input int b);
    drive(a, b, 1'b1);
    step();
  endtask

  initial begin
    // Reset without checks: outputs are unknown until the first reset edge.
    reset   = 1'b1;
    clk_en  = 1'b1;
    o_ready = 1'b1;
    drive(0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    m_pairs = 0;
    m_sum   = 0;
    m_ov    = 1'b0;
    m_od    = '0;
    reset   = 1'b0;
    check("reset_o_valid", {63'd0, o_valid}, 64'd0);
    check("reset_o_data",  {16'd0, o_data},  64'd0);
    check("reset_i_ready", {63'd0, i_ready}, 64'd1);

    // Basic: a=1..4, b=2 -> 20.
    for (int i = 1; i <= 4; i++) feed(i, 2);
    drive(0, 0, 1'b0);
    check("basic_valid", {63'd0, o_valid}, 64'd1);
    check("basic_data",  {16'd0, o_data},  64'd20);
    step();
    check("basic_one_cycle", {63'd0, o_valid}, 64'd0);

    // Signed operands -> -28.
    feed(-3, 5); feed(7, -2); feed(-1, -1); feed(0, 9);
    drive(0, 0, 1'b0);
    check("signed_data", {16'd0, o_data}, 64'h0000_FFFF_FFFF_FFE4);
    step();

    // Extremes: 4 * (-32768)^2 = 2^32.
    for (int i = 0; i < 4; i++) feed(-32768, -32768);
    drive(0, 0, 1'b0);
    check("extreme_data", {16'd0, o_data}, 64'h0000_0001_0000_0000);
    step();

    // Backpressure: result 20 stays pending; group 2 stalls on its 4th pair.
    o_ready = 1'b0;
    for (int i = 1; i <= 4; i++) feed(i, 2);
    for (int i = 0; i < 4; i++) feed(1, 1);
    drive(1, 1, 1'b1);
    step();
    check("bp_i_ready_low", {63'd0, i_ready}, 64'd0);
    check("bp_data_held",   {16'd0, o_data},  64'd20);
    check("bp_valid_held",  {63'd0, o_valid}, 64'd1);

    // Release: 4th pair fires together with consumption of the old result.
    o_ready = 1'b1;
    step();
    drive(0, 0, 1'b0);
    check("simul_valid", {63'd0, o_valid}, 64'd1);
    check("simul_data",  {16'd0, o_data},  64'd4);
    step();

    // Stall after 2 pairs, then finish the group.
    feed(1, 2); feed(3, 2);
    clk_en = 1'b0;
    drive(9, 9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_i_ready", {63'd0, i_ready}, 64'd0);
    end
    clk_en = 1'b1;
    feed(1, 2); feed(3, 2);
    drive(0, 0, 1'b0);
    check("stall_data", {16'd0, o_data}, 64'd16);
    step();

    // Reset mid-group discards the partial sum.
    feed(5, 5); feed(5, 5);
    drive(0, 0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) feed(1, 1);
    drive(0, 0, 1'b0);
    check("reset_mid_data", {16'd0, o_data}, 64'd4);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) drive(-32768, ($urandom_range(0, 1) == 1) ? -32768 : 32767, 1'b1);
      else drive(int'($urandom), int'($urandom), $urandom_range(0, 9) < 8);
      o_ready = $urandom_range(0, 9) < 7;
      clk_en  = $urandom_range(0, 9) < 9;
      reset   = $urandom_range(0, 99) == 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
